moore_overlap_1101: RTL and testbench
=====================================

Name: moore_overlap_1101

Overview:
- Moore-type, overlapping serial sequence detector for the bit pattern 1101, arriving MSB-first, one bit per clock.
- Samples a single-bit serial stream on each rising clock edge.
- Raises a one-cycle flag whenever the most recent four sampled bits equal 1101, including matches that share bits with the previous match.
- Used as a leaf pattern-recognition block feeding control logic; the output is a pure function of the state register.

Parameters:
- none (the pattern 1101 is fixed in the design).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; forces the idle state immediately, independent of clk.
- in   input  1  serial data bit, sampled on each rising edge of clk.
- out  output 1  detection flag; high for one cycle after the final bit of 1101 is sampled.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Ports are named clk and rst.
- State register is 3 bits wide and updates on posedge clk or posedge rst.
- States:
  - S0 = idle / no prefix matched
  - S1 = "1" matched
  - S2 = "11" matched
  - S3 = "110" matched
  - S4 = "1101" detected
- Transitions (next state for in=0 / in=1):
  - S0 -> S0 / S1
  - S1 -> S0 / S2
  - S2 -> S3 / S2 (a run of 1s keeps the "11" prefix)
  - S3 -> S0 / S4
  - S4 -> S0 / S2 (overlap: the trailing 1 of the match plus the new 1 forms "11")
- Output: out = 1 only when the state is S4; otherwise 0. out has no combinational path from in (Moore).
- Latency: out rises in the cycle that follows the rising edge which samples the last '1' of 1101. It stays high for exactly one clock period.
- Back-to-back overlap: input 1101101 produces two pulses, 3 cycles apart.
- Reset:
  - While rst is high, the state is S0 and out = 0, regardless of clk or in.
  - Values of in (including X/undriven) are ignored while rst is high.
  - Assertion mid-sequence discards any partial match immediately (asynchronously).
  - After rst deasserts, detection restarts from S0; bits sampled before the release never contribute to a match.
- Illegal state codes (5, 6, 7) must return to S0 on the next clock edge with out = 0. A default branch must cover every case, so no latches are inferred.
- Only the state register is clocked; next-state and output logic are combinational.

Test Plan:
- Reset: hold rst=1 for 10 ns with clk running and in undriven -> out=0 throughout; state is S0 when rst falls.
- Basic detect: after reset, sample 0,1,0,1,1,0,1 -> out=0 until the 7th sampled bit, then out=1 for exactly one cycle.
- Run of ones: continue with 1,1,1,0,1 -> out=0 on the first 1 (S4->S2), stays 0 through 1,1,0, then pulses 1 for one cycle after the final 1.
- No false match: continue with 0,1 -> out=0 (S4->S0->S1).
- Overlap: sample 1,1,0,1,1,0,1 from S0 -> out pulses on the 4th and 7th sampled bits only.
- Mid-sequence reset: sample 1,1,0, pulse rst for half a cycle, then sample 1 -> out stays 0. A fresh 1,1,0,1 afterwards -> a single pulse.

Source files
------------

// File: rtl/moore_overlap_1101.sv
// Overlapping Moore detector for the serial pattern 1101 (MSB first).
// The out flag is decoded from the state register only and is never a combinational function of in.
module moore_overlap_1101 (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam logic [2:0] S0 = 3'd0;  // idle, no prefix matched
  localparam logic [2:0] S1 = 3'd1;  // "1"
  localparam logic [2:0] S2 = 3'd2;  // "11"
  localparam logic [2:0] S3 = 3'd3;  // "110"
  localparam logic [2:0] S4 = 3'd4;  // "1101" detected

  logic [2:0] state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = in ? S1 : S0;
      S1:      state_d = in ? S2 : S0;
      S2:      state_d = in ? S2 : S3;
      S3:      state_d = in ? S4 : S0;
      // Overlap: the trailing 1 of the match plus a new 1 already forms "11".
      S4:      state_d = in ? S2 : S0;
      default: state_d = S0;
    endcase
  end

  always_comb begin
    out = (state_q == S4);
  end

endmodule

// File: tb/tb_moore_overlap_1101.sv
// Bench for moore_overlap_1101: table of {bit, expected flag} vectors fed through a scoreboard
// queue, plus hand-written sequences for asynchronous reset behaviour.
module tb_moore_overlap_1101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_bit;
  logic out_bit;

  always #5 clk = ~clk;

  moore_overlap_1101 dut (
    .clk (clk),
    .rst (rst),
    .in  (in_bit),
    .out (out_bit)
  );

  typedef struct {
    logic din;
    logic exp;
  } vec_t;

  localparam int NumVecs = 22;
  vec_t vecs[NumVecs];
  logic exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: out=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive the bit, let the posedge sample it, compare at the next negedge.
  task automatic apply(input logic b, input logic e, input string name);
    in_bit = b;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, out=%b", name, out_bit);
    end else begin
      check(name, out_bit, exp_q.pop_front());
    end
  endtask

  initial begin
    // Basic detect: 0,1,0,1,1,0,1
    vecs[0]  = '{1'b0, 1'b0}; vecs[1]  = '{1'b1, 1'b0}; vecs[2]  = '{1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0}; vecs[4]  = '{1'b1, 1'b0}; vecs[5]  = '{1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1};
    // Run of ones: 1,1,1,0,1
    vecs[7]  = '{1'b1, 1'b0}; vecs[8]  = '{1'b1, 1'b0}; vecs[9]  = '{1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0}; vecs[11] = '{1'b1, 1'b1};
    // No false match: 0,1, then 0 to return to idle
    vecs[12] = '{1'b0, 1'b0}; vecs[13] = '{1'b1, 1'b0}; vecs[14] = '{1'b0, 1'b0};
    // Overlap: 1,1,0,1,1,0,1 pulses on the 4th and 7th bits
    vecs[15] = '{1'b1, 1'b0}; vecs[16] = '{1'b1, 1'b0}; vecs[17] = '{1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1}; vecs[19] = '{1'b1, 1'b0}; vecs[20] = '{1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1};

    // Reset held with clock running and in undriven.
    in_bit = 1'bx;
    #1;
    check("reset_t1", out_bit, 1'b0);
    @(posedge clk);
    #1;
    check("reset_after_edge", out_bit, 1'b0);
    @(negedge clk);
    check("reset_t10", out_bit, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_release", out_bit, 1'b0);
    @(negedge clk);

    for (int i = 0; i < NumVecs; i++) begin
      apply(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Mid-sequence asynchronous reset discards the "110" prefix.
    apply(1'b1, 1'b0, "mid_1");
    apply(1'b1, 1'b0, "mid_11");
    apply(1'b0, 1'b0, "mid_110");
    #1 rst = 1'b1;
    #1 check("async_rst_out", out_bit, 1'b0);
    #1 rst = 1'b0;
    apply(1'b1, 1'b0, "after_rst_1");
    apply(1'b1, 1'b0, "fresh_1");
    apply(1'b1, 1'b0, "fresh_11");
    apply(1'b0, 1'b0, "fresh_110");
    apply(1'b1, 1'b1, "fresh_1101");
    apply(1'b0, 1'b0, "fresh_pulse_end");

    // Reset while the flag is high clears it immediately.
    apply(1'b1, 1'b0, "hi_1");
    apply(1'b1, 1'b0, "hi_11");
    apply(1'b0, 1'b0, "hi_110");
    apply(1'b1, 1'b1, "hi_1101");
    #1 rst = 1'b1;
    #1 check("async_rst_clears_flag", out_bit, 1'b0);
    #1 rst = 1'b0;
    apply(1'b0, 1'b0, "post_flag_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
